// File: rtl/imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// imem_fetch_unit
// Instruction memory with a fixed-latency fetch port and a program-load port.
// A fetch is accepted on fetch_valid && fetch_ready. The response appears
// READ_LATENCY cycles later and is held until the consumer takes it with
// inst_ready. Misaligned or out-of-range fetches take the same time and return
// inst_fault=1 with zero data. Array contents survive reset.
//
// Ports
//   CLK          in   rising-edge clock
//   Reset_L      in   synchronous active-low reset
//   fetch_valid  in   fetch request present
//   fetch_addr   in   byte address of requested instruction
//   fetch_ready  out  unit can accept a fetch this cycle (combinational)
//   inst_valid   out  response present
//   inst_data    out  fetched instruction word (0 when not valid or faulted)
//   inst_fault   out  response is a misaligned / out-of-range fault
//   inst_ready   in   consumer accepts the response
//   load_en      in   program-load write strobe
//   load_addr    in   byte address of the load
//   load_data    in   word to write
// -----------------------------------------------------------------------------
module imem_fetch_unit #(
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  CLK,
    input  logic                  Reset_L,
    input  logic                  fetch_valid,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ready,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic                  inst_fault,
    input  logic                  inst_ready,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data
);

    localparam int unsigned BYTES     = DATA_WIDTH / 8;
    localparam int unsigned OFF_W     = $clog2(BYTES);
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(READ_LATENCY + 1);
    localparam bit          SKIP_WAIT = (READ_LATENCY == 1);

    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_fault;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_fetch_ready;
    logic                  w_accept;
    logic                  w_enter_hold;
    logic                  w_release;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_rd_ok;
    logic                  w_ld_ok;

    // Aligned and inside the array.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return ((a & OFF_MASK) == '0) && ((a >> OFF_W) < DEPTH_A);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(a >> OFF_W);
    endfunction

    // Handshake qualifiers; a load in flight blocks new fetches.
    assign w_fetch_ready = Reset_L && !load_en &&
                           ((r_state == S_IDLE) || ((r_state == S_HOLD) && inst_ready));
    assign w_accept      = fetch_valid && w_fetch_ready;
    assign w_release     = (r_state == S_HOLD) && inst_ready;

    // With latency 1 the read happens on the accept edge, so use the live address.
    assign w_rd_addr = SKIP_WAIT ? fetch_addr : r_addr;
    assign w_rd_ok   = addr_ok(w_rd_addr);
    assign w_ld_ok   = addr_ok(load_addr);

    // State register.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; w_enter_hold marks the edge on which the array is read.
    always_comb begin
        w_next_state = r_state;
        w_enter_hold = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (SKIP_WAIT) begin
                        w_next_state = S_HOLD;
                        w_enter_hold = 1'b1;
                    end else begin
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == LAST_CNT) begin
                    w_next_state = S_HOLD;
                    w_enter_hold = 1'b1;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    if (w_accept) begin
                        if (SKIP_WAIT) begin
                            w_next_state = S_HOLD;
                            w_enter_hold = 1'b1;
                        end else begin
                            w_next_state = S_WAIT;
                        end
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Latency counter, captured address and registered response.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_fault <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= fetch_addr;
            end

            // Counter holds the number of cycles already spent since accept.
            if (w_next_state == S_WAIT) begin
                r_cnt <= (r_state == S_WAIT) ? r_cnt + CNT_W'(1) : CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end

            // Non-blocking read sees the pre-write word if a load hits it this edge.
            if (w_enter_hold) begin
                r_valid <= 1'b1;
                r_fault <= !w_rd_ok;
                r_data  <= w_rd_ok ? r_mem[addr_idx(w_rd_addr)] : '0;
            end else if (w_release) begin
                r_valid <= 1'b0;
                r_fault <= 1'b0;
                r_data  <= '0;
            end
        end
    end

    // Program-load port; bad addresses are dropped, contents are never reset.
    always_ff @(posedge CLK) begin
        if (Reset_L && load_en && w_ld_ok) begin
            r_mem[addr_idx(load_addr)] <= load_data;
        end
    end

    assign fetch_ready = w_fetch_ready;
    assign inst_valid  = r_valid;
    assign inst_data   = r_data;
    assign inst_fault  = r_fault;

endmodule
